// File: rtl/alu_pkg.sv
// Shared definitions for the sequential sign-magnitude ALU.
//   op_e    : 4-bit operation codes as presented on the op port
//   state_e : control FSM states (IDLE / ITER / DONE)
//   FLAG_*  : bit positions of each status flag in the downstream flag register
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_INC   = 4'h2,
    OP_DEC   = 4'h3,
    OP_MUL   = 4'h4,
    OP_DIV   = 4'h5,
    OP_XOR   = 4'h6,
    OP_AND   = 4'h7,
    OP_OR    = 4'h8,
    OP_XNOR  = 4'h9,
    OP_NAND  = 4'hA,
    OP_NOR   = 4'hB,
    OP_PASS1 = 4'hC,
    OP_PASS2 = 4'hD,
    OP_NOT1  = 4'hE,
    OP_NOT2  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Flag register bit positions.
  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_PARITY = 2;
  localparam int FLAG_EQUAL  = 3;
  localparam int FLAG_GT     = 4;
  localparam int FLAG_OVF    = 5;
  localparam int FLAG_DBZ    = 6;
  localparam int FLAG_SIGN   = 7;
  localparam int FLAG_W      = 8;

  // MUL and DIV walk the magnitude one bit per cycle; everything else is one cycle.
  function automatic logic is_iterative(input op_e op_i);
    return (op_i == OP_MUL) || (op_i == OP_DIV);
  endfunction

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude adder/subtractor.
//   a, b  : WIDTH-bit sign-magnitude operands (MSB = sign)
//   sub   : 1 = compute a - b (b's sign inverted), 0 = a + b
//   sign  : result sign, never 1 for a zero magnitude
//   mag   : result magnitude (wraps on overflow)
//   carry : carry out of the magnitude MSB (only possible for like signs)
module sm_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             sign,
  output logic [WIDTH-2:0] mag,
  output logic             carry
);

  localparam int MAG_W = WIDTH - 1;

  logic             a_sign;
  logic             b_sign;
  logic [MAG_W-1:0] a_mag;
  logic [MAG_W-1:0] b_mag;
  logic [MAG_W:0]   sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sign   = 1'b0;
    mag    = '0;
    carry  = 1'b0;
    a_sign = a[WIDTH-1];
    b_sign = b[WIDTH-1] ^ sub;
    a_mag  = a[MAG_W-1:0];
    b_mag  = b[MAG_W-1:0];
    sum    = {1'b0, a_mag} + {1'b0, b_mag};

    if (a_sign == b_sign) begin
      mag   = sum[MAG_W-1:0];
      carry = sum[MAG_W];
      sign  = a_sign;
    end else if (a_mag >= b_mag) begin
      mag  = a_mag - b_mag;
      sign = a_sign;
    end else begin
      mag  = b_mag - a_mag;
      sign = b_sign;
    end

    // No negative zero.
    if (mag == '0) begin
      sign = 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sign-magnitude ALU with start/busy/done handshake.
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   start, op, in1, in2   : request, op code and operands, sampled only in IDLE
//   busy                  : operation in flight (ITER or DONE)
//   done                  : one-cycle pulse; result outputs valid from here on
//   result, result_hi     : primary result; product high / remainder magnitude
//   carry_out .. div_by_zero : status flags, held with the result
// Single-cycle ops finish on the accept edge; MUL/DIV spend WIDTH-1 cycles in
// ITER processing one magnitude bit each (shift-add / restoring division).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-2:0] result_hi,
  output logic             carry_out,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             equal,
  output logic             greater_than,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int MAG_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAG_W - 1);

  // State and operand registers.
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Iteration registers: MUL {partial high, multiplier/product low},
  // DIV {partial remainder, dividend/quotient}.
  logic [MAG_W-1:0] hi_q, hi_d;
  logic [MAG_W-1:0] lo_q, lo_d;
  // Output registers, loaded on the edge that enters DONE.
  logic [WIDTH-1:0]  result_q, result_d;
  logic [MAG_W-1:0]  result_hi_q, result_hi_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  // Operand view: the live ports while IDLE (accept edge), the latched copy afterwards.
  logic             in_idle;
  op_e              src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             a_sign, b_sign;
  logic [MAG_W-1:0] a_mag, b_mag;
  logic             div_zero;
  logic             needs_iter;

  assign in_idle    = (state_q == ST_IDLE);
  assign src_op     = in_idle ? op_e'(op) : op_q;
  assign src_a      = in_idle ? in1 : in1_q;
  assign src_b      = in_idle ? in2 : in2_q;
  assign a_sign     = src_a[WIDTH-1];
  assign b_sign     = src_b[WIDTH-1];
  assign a_mag      = src_a[MAG_W-1:0];
  assign b_mag      = src_b[MAG_W-1:0];
  assign div_zero   = (src_op == OP_DIV) && (b_mag == '0);
  assign needs_iter = is_iterative(src_op) && !div_zero;

  // ADD/SUB/INC/DEC share one sign-magnitude adder; INC/DEC use a +1 operand.
  logic             as_sub;
  logic [WIDTH-1:0] as_b;
  logic             as_sign;
  logic [MAG_W-1:0] as_mag;
  logic             as_carry;

  assign as_sub = (src_op == OP_SUB) || (src_op == OP_DEC);
  assign as_b   = ((src_op == OP_INC) || (src_op == OP_DEC)) ? WIDTH'(1) : src_b;

  sm_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a     (src_a),
    .b     (as_b),
    .sub   (as_sub),
    .sign  (as_sign),
    .mag   (as_mag),
    .carry (as_carry)
  );

  // Numeric comparison; +0 and -0 are equal.
  logic cmp_eq, cmp_gt;

  always_comb begin
    cmp_eq = (a_mag == b_mag) && ((a_sign == b_sign) || (a_mag == '0));
    if (cmp_eq) begin
      cmp_gt = 1'b0;
    end else if (a_sign != b_sign) begin
      cmp_gt = ~a_sign;
    end else if (a_sign) begin
      cmp_gt = (a_mag < b_mag);
    end else begin
      cmp_gt = (a_mag > b_mag);
    end
  end

  // One iteration step of MUL or DIV.
  logic [MAG_W:0]   mul_sum;
  logic [MAG_W:0]   div_trial;
  logic [MAG_W:0]   div_diff;
  logic             div_fits;
  logic [MAG_W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag} : '0);
    div_trial = {hi_q, lo_q[MAG_W-1]};
    div_diff  = div_trial - {1'b0, b_mag};
    div_fits  = (div_trial >= {1'b0, b_mag});
    if (src_op == OP_DIV) begin
      // A remainder that does not fit is restored by simply keeping the trial value.
      step_hi = div_fits ? div_diff[MAG_W-1:0] : div_trial[MAG_W-1:0];
      step_lo = {lo_q[MAG_W-2:0], div_fits};
    end else begin
      // Shift the {carry, partial, multiplier} chain right one place.
      step_hi = mul_sum[MAG_W:1];
      step_lo = {mul_sum[0], lo_q[MAG_W-1:1]};
    end
  end

  // Final values for the output registers. For MUL/DIV this is only used on the
  // last ITER edge (or the divide-by-zero shortcut), where step_* is final.
  logic [WIDTH-1:0]  fin_result;
  logic [MAG_W-1:0]  fin_hi;
  logic              fin_carry, fin_ovf, fin_dbz;
  logic [FLAG_W-1:0] fin_flags;

  always_comb begin
    fin_result = '0;
    fin_hi     = '0;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    fin_dbz    = 1'b0;
    case (src_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        fin_result = {as_sign, as_mag};
        fin_carry  = as_carry;
        fin_ovf    = as_carry;
      end
      OP_MUL: begin
        fin_result = {(a_sign ^ b_sign) & (|{step_hi, step_lo}), step_lo};
        fin_hi     = step_hi;
        fin_ovf    = |step_hi;
      end
      OP_DIV: begin
        if (div_zero) begin
          fin_dbz = 1'b1;
        end else begin
          fin_result = {(a_sign ^ b_sign) & (|step_lo), step_lo};
          fin_hi     = step_hi;
        end
      end
      OP_XOR:   fin_result = src_a ^ src_b;
      OP_AND:   fin_result = src_a & src_b;
      OP_OR:    fin_result = src_a | src_b;
      OP_XNOR:  fin_result = ~(src_a ^ src_b);
      OP_NAND:  fin_result = ~(src_a & src_b);
      OP_NOR:   fin_result = ~(src_a | src_b);
      OP_PASS1: fin_result = src_a;
      OP_PASS2: fin_result = src_b;
      OP_NOT1:  fin_result = ~src_a;
      OP_NOT2:  fin_result = ~src_b;
    endcase

    fin_flags              = '0;
    fin_flags[FLAG_CARRY]  = fin_carry;
    fin_flags[FLAG_ZERO]   = ~|fin_result[MAG_W-1:0];
    fin_flags[FLAG_PARITY] = ~^fin_result[MAG_W-1:0];
    fin_flags[FLAG_EQUAL]  = cmp_eq;
    fin_flags[FLAG_GT]     = cmp_gt;
    fin_flags[FLAG_OVF]    = fin_ovf;
    fin_flags[FLAG_DBZ]    = fin_dbz;
    fin_flags[FLAG_SIGN]   = fin_result[WIDTH-1];
  end

  // Control FSM: next state and register updates.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_e'(op);
          in1_d = in1;
          in2_d = in2;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = in1[MAG_W-1:0];
          if (needs_iter) begin
            state_d = ST_ITER;
          end else begin
            state_d     = ST_DONE;
            result_d    = fin_result;
            result_hi_d = fin_hi;
            flags_d     = fin_flags;
          end
        end
      end
      ST_ITER: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == LAST_STEP) begin
          state_d     = ST_DONE;
          result_d    = fin_result;
          result_hi_d = fin_hi;
          flags_d     = fin_flags;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      in1_q       <= '0;
      in2_q       <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign busy         = !in_idle;
  assign done         = (state_q == ST_DONE);
  assign result       = result_q;
  assign result_hi    = result_hi_q;
  assign carry_out    = flags_q[FLAG_CARRY];
  assign sign         = flags_q[FLAG_SIGN];
  assign zero         = flags_q[FLAG_ZERO];
  assign parity       = flags_q[FLAG_PARITY];
  assign equal        = flags_q[FLAG_EQUAL];
  assign greater_than = flags_q[FLAG_GT];
  assign overflow     = flags_q[FLAG_OVF];
  assign div_by_zero  = flags_q[FLAG_DBZ];

endmodule
